npu_feeder: RTL
===============

NPU_FEEDER -- requirements
Module: npu_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16: beat-buffer depth in 64-bit entries, and the maximum job length.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 15: idle cycles after the config beat before the next job may start.
REQ-003 SHALL have ports:
- CLKEXT  in  1  single clock, rising edge.
- RST_GLO_N  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  job command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_len  in  5  accumulation count N.
- cmd_bias  in  32  MAC1..MAC4 bias bytes, MAC1 in [31:24].
- cmd_ssfr  in  16  SSFR word for the config beat.
- in_valid  in  1  pixel/weight beat valid.
- in_ready  out  1  beat accepted when high with in_valid.
- in_data  in  64  {DA,DB,DC,DD,DE,DF,DG,DH}, DA in [63:56].
- DA..DH  out  8 each  registered NPU data bus.
- EN_FSM  out  1  NPU start pulse.
- EN_CONFIG  out  1  NPU SSFR load strobe.
- SEL_CON  out  1  NPU auto-mode select.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  one-cycle pulse when a command is rejected.

Function
REQ-004 SHALL register all outputs on the CLKEXT rising edge; each NPU beat lasts exactly one cycle.
REQ-005 SHALL drive SEL_CON=1 in every cycle after reset release.
REQ-006 SHALL implement states IDLE, WAIT_FILL, ARM, BIAS, DATA, CONFIG, DRAIN.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; on handshake it latches len, bias and ssfr.
REQ-008 SHALL reject a command with len=0 or len>DEPTH: err=1 for one cycle, state stays IDLE.
REQ-009 SHALL move from WAIT_FILL to ARM in the first cycle the buffer count is >= len.
REQ-010 In ARM, SHALL drive EN_FSM=1 for exactly one cycle with DA..DH=0.
REQ-011 In BIAS, SHALL drive one cycle of: DA=bias[31:24], DC=bias[23:16], DE=bias[15:8], DG=bias[7:0], DB=0, DD={3'b0,len}, DF=DH=0.
REQ-012 In DATA, SHALL pop one beat per cycle onto DA..DH for exactly len consecutive cycles, with no gaps.
REQ-013 In CONFIG, SHALL drive one cycle of EN_CONFIG=1, DA=ssfr[15:8], DB=ssfr[7:0], all other lanes 0.
REQ-014 In DRAIN, SHALL count DRAIN_CYCLES cycles with all lanes 0, then return to IDLE.
REQ-015 Outside the BIAS, DATA and CONFIG states, SHALL drive DA..DH=0, EN_FSM=0 (except ARM) and EN_CONFIG=0.
REQ-016 SHALL drive in_ready = buffer not full, in every state.
REQ-017 SHALL accept beats for the next job during any state.
REQ-018 On a simultaneous push and pop, the buffer count SHALL stay unchanged; a push while full is impossible because in_ready=0.
REQ-019 The buffer SHALL be FIFO-ordered; the read pointer SHALL wrap from DEPTH-1 to 0.

Reset
REQ-020 While RST_GLO_N=0: state=IDLE, buffer empty, DA..DH=0, EN_FSM=0, EN_CONFIG=0, SEL_CON=0, busy=0, err=0, cmd_ready=0, in_ready=0.
REQ-021 A reset in the middle of a job SHALL abort the job and discard all buffered beats.

Configuration
REQ-022 When NPU_FEEDER_STATS_EN is defined, SHALL add output job_count, 16 bits:
- reset value 0;
- increments when DRAIN completes;
- wraps 0xFFFF to 0.
REQ-023 When NPU_FEEDER_STATS_EN is undefined, job_count SHALL be absent and all other behaviour unchanged.

Structure
REQ-024 Package npu_feeder_pkg SHALL hold the state enum, default DEPTH/DRAIN_CYCLES constants, and the byte-lane bit positions.
REQ-025 The buffer SHALL be sub-module npu_feeder_fifo: synchronous, width 64, depth DEPTH, outputs count/full/empty.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Nominal: cmd len=9, bias=0x01010101, ssfr=0x20A8, 9 beats of 0x0102010201020102 -> EN_FSM pulse, BIAS beat DD=0x09, 9 contiguous data beats, EN_CONFIG with DA=0x20 DB=0xA8, then 15 idle cycles.
- Fill stall: cmd len=4 with beats arriving one every 3 cycles -> stays in WAIT_FILL until the 4th beat, then emits 4 beats back-to-back.
- Reject: cmd len=0, and cmd len=17 -> one-cycle err pulse each, no EN_FSM.
- Full/overlap: push 16 beats -> in_ready=0; start job len=16; beats of the next job are accepted as entries free, and ordering is preserved.
- Reset mid-DATA after 3 beats -> all outputs 0 immediately, buffer empty after release, next job runs cleanly.
- STATS_EN: 3 jobs -> job_count=3; preload 0xFFFF via force, one job -> 0.

Source files
------------

// File: rtl/npu_feeder_pkg.sv
// npu_feeder_pkg: shared definitions for the NPU feeder.
//   state_t              - feeder sequencer states
//   DEFAULT_DEPTH        - default beat-buffer depth (64-bit entries)
//   DEFAULT_DRAIN_CYCLES - default idle cycles after the config beat
//   DA_LSB .. DH_LSB     - bit position of each byte lane inside a 64-bit beat
package npu_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILL,
    ARM,
    BIAS,
    DATA,
    CONFIG,
    DRAIN
  } state_t;

  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_DRAIN_CYCLES = 15;

  // Beat layout {DA,DB,DC,DD,DE,DF,DG,DH}, DA in the top byte.
  localparam int DA_LSB = 56;
  localparam int DB_LSB = 48;
  localparam int DC_LSB = 40;
  localparam int DD_LSB = 32;
  localparam int DE_LSB = 24;
  localparam int DF_LSB = 16;
  localparam int DG_LSB = 8;
  localparam int DH_LSB = 0;

endpackage

// File: rtl/npu_feeder_fifo.sv
// npu_feeder_fifo: synchronous show-ahead beat buffer.
//   CLKEXT    in   clock, rising edge
//   RST_GLO_N in   asynchronous active-low reset (empties the buffer)
//   push      in   write wr_data (ignored when full)
//   wr_data   in   WIDTH-bit beat
//   pop       in   drop the head entry (ignored when empty)
//   rd_data   out  head entry, valid whenever empty=0
//   count     out  number of stored entries
//   full      out  count == DEPTH
//   empty     out  count == 0
module npu_feeder_fifo
  import npu_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge CLKEXT) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/npu_feeder.sv
// npu_feeder: buffers 64-bit pixel/weight beats and replays them to the NPU as
// one job: start pulse, bias beat, len data beats, SSFR config beat, drain gap.
// Optional feature macro: NPU_FEEDER_STATS_EN adds the job_count output.
//   CLKEXT            in   clock, rising edge
//   RST_GLO_N         in   asynchronous active-low reset
//   cmd_valid/ready   in/out  job command handshake (ready only in IDLE)
//   cmd_len           in   data beats in the job (1..DEPTH accepted)
//   cmd_bias          in   MAC1..MAC4 bias bytes, MAC1 in [31:24]
//   cmd_ssfr          in   SSFR word sent in the config beat
//   in_valid/ready    in/out  beat handshake (ready = buffer not full)
//   in_data           in   {DA..DH}, DA in [63:56]
//   DA..DH            out  registered NPU data lanes
//   EN_FSM            out  NPU start pulse (ARM)
//   EN_CONFIG         out  NPU SSFR load strobe (CONFIG)
//   SEL_CON           out  NPU auto-mode select, 1 after reset release
//   busy              out  state != IDLE
//   err               out  one-cycle pulse on a rejected command
//   job_count         out  completed jobs, wraps (NPU_FEEDER_STATS_EN only)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload until that edge, ready never depends
// combinationally on valid.
module npu_feeder
  import npu_feeder_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_bias,
  input  logic [15:0] cmd_ssfr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [7:0]  DA,
  output logic [7:0]  DB,
  output logic [7:0]  DC,
  output logic [7:0]  DD,
  output logic [7:0]  DE,
  output logic [7:0]  DF,
  output logic [7:0]  DG,
  output logic [7:0]  DH,
  output logic        EN_FSM,
  output logic        EN_CONFIG,
  output logic        SEL_CON,
  output logic        busy,
  output logic        err
`ifdef NPU_FEEDER_STATS_EN
  ,
  output logic [15:0] job_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t         state;
  logic [4:0]     len_q;
  logic [31:0]    bias_q;
  logic [15:0]    ssfr_q;
  logic [4:0]     left_q;   // data beats still to pop after the current one
  logic [DW-1:0]  drain_q;

  logic [63:0]    fifo_rd_data;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           pop_want;
  logic [CW-1:0]  cnt_next;
  logic           cmd_ok;

  assign push     = in_valid && in_ready && !fifo_full;
  // The beat registered onto the lanes at this edge leaves the buffer now.
  assign pop_want = (state == BIAS) || ((state == DATA) && (left_q != '0));
  assign pop      = pop_want && !fifo_empty;
  assign cnt_next = fifo_count + CW'(push) - CW'(pop);
  assign cmd_ok   = (cmd_len != '0) && (int'(cmd_len) <= DEPTH);

  npu_feeder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .CLKEXT    (CLKEXT),
    .RST_GLO_N (RST_GLO_N),
    .push      (push),
    .wr_data   (in_data),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      state     <= IDLE;
      len_q     <= '0;
      bias_q    <= '0;
      ssfr_q    <= '0;
      left_q    <= '0;
      drain_q   <= '0;
      {DA, DB, DC, DD, DE, DF, DG, DH} <= '0;
      EN_FSM    <= 1'b0;
      EN_CONFIG <= 1'b0;
      SEL_CON   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      in_ready  <= 1'b0;
`ifdef NPU_FEEDER_STATS_EN
      job_count <= '0;
`endif
    end else begin
      SEL_CON   <= 1'b1;
      in_ready  <= (cnt_next != CW'(DEPTH));
      err       <= 1'b0;
      EN_FSM    <= 1'b0;
      EN_CONFIG <= 1'b0;
      {DA, DB, DC, DD, DE, DF, DG, DH} <= '0;
      // busy/cmd_ready describe the state being entered at this edge.
      busy      <= 1'b1;
      cmd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready && cmd_ok) begin
            len_q  <= cmd_len;
            bias_q <= cmd_bias;
            ssfr_q <= cmd_ssfr;
            state  <= WAIT_FILL;
          end else begin
            err       <= cmd_valid && cmd_ready;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        WAIT_FILL: begin
          // Whole job buffered before starting, so DATA never stalls.
          if (int'(fifo_count) >= int'(len_q)) begin
            state  <= ARM;
            EN_FSM <= 1'b1;
          end
        end
        ARM: begin
          state <= BIAS;
          DA    <= bias_q[31:24];
          DC    <= bias_q[23:16];
          DE    <= bias_q[15:8];
          DG    <= bias_q[7:0];
          DD    <= {3'b000, len_q};
        end
        BIAS: begin
          state  <= DATA;
          left_q <= len_q - 5'd1;
          {DA, DB, DC, DD} <= {fifo_rd_data[DA_LSB +: 8], fifo_rd_data[DB_LSB +: 8],
                               fifo_rd_data[DC_LSB +: 8], fifo_rd_data[DD_LSB +: 8]};
          {DE, DF, DG, DH} <= {fifo_rd_data[DE_LSB +: 8], fifo_rd_data[DF_LSB +: 8],
                               fifo_rd_data[DG_LSB +: 8], fifo_rd_data[DH_LSB +: 8]};
        end
        DATA: begin
          if (left_q != '0) begin
            left_q <= left_q - 5'd1;
            {DA, DB, DC, DD} <= {fifo_rd_data[DA_LSB +: 8], fifo_rd_data[DB_LSB +: 8],
                                 fifo_rd_data[DC_LSB +: 8], fifo_rd_data[DD_LSB +: 8]};
            {DE, DF, DG, DH} <= {fifo_rd_data[DE_LSB +: 8], fifo_rd_data[DF_LSB +: 8],
                                 fifo_rd_data[DG_LSB +: 8], fifo_rd_data[DH_LSB +: 8]};
          end else begin
            state     <= CONFIG;
            EN_CONFIG <= 1'b1;
            DA        <= ssfr_q[15:8];
            DB        <= ssfr_q[7:0];
          end
        end
        CONFIG: begin
          state   <= DRAIN;
          drain_q <= DW'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef NPU_FEEDER_STATS_EN
            job_count <= job_count + 16'd1;
`endif
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
